// File: rtl/accel_fifo_pkg.sv
// Shared defaults and sizing helpers for the accelerator FIFO port.
package accel_fifo_pkg;

  localparam int unsigned ACCEL_WIDTH = 128;
  localparam int unsigned ACCEL_DEPTH = 8;

  // Pointer width for a power-of-two depth; the occupancy count is one bit
  // wider so that "full" (count == DEPTH) is representable.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered empty/full flags, a registered pop port
// (1-cycle latency, data held between pops) and per-cycle error pulses.
module sync_fifo
  import accel_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = ACCEL_WIDTH,
  parameter int unsigned DEPTH = ACCEL_DEPTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             pop_valid_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             ovf_o,
  output logic             udf_o
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, full_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             push_ok, pop_ok;

  // Accept decisions use the flags as registered at the edge, so a push
  // while full is dropped even when a pop frees a slot in the same cycle.
  always_comb begin
    push_ok  = push_i & ~full_q;
    pop_ok   = pop_i & ~empty_q;
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers, count, flags and the registered pop port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == CW'(DEPTH));
      valid_q  <= pop_ok;
      if (pop_ok) data_q <= mem_q[rd_ptr_q];
    end
  end

  // Storage needs no reset: contents are only reachable through the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o  = data_q;
  assign pop_valid_o = valid_q;
  assign empty_o     = empty_q;
  assign full_o      = full_q;
  assign ovf_o       = push_i & full_q;
  assign udf_o       = pop_i & empty_q;

endmodule

// File: rtl/accel_fifo_port.sv
// Router <-> accelerator port: TX FIFO (router to accelerator), RX FIFO
// (accelerator to router) and sticky protocol-error flags.
module accel_fifo_port
  import accel_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = ACCEL_WIDTH,
  parameter int unsigned DEPTH = ACCEL_DEPTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             put_req,
  input  logic [WIDTH-1:0] data_in,
  input  logic             get_req,
  output logic [WIDTH-1:0] data_out,
  output logic             data_out_valid,
  output logic             to_acc_empty,
  output logic             to_acc_full,
  output logic             from_acc_empty,
  output logic             from_acc_full,
  input  logic             acc_rd_req,
  output logic [WIDTH-1:0] acc_rd_data,
  output logic             acc_rd_valid,
  input  logic             acc_wr_req,
  input  logic [WIDTH-1:0] acc_wr_data,
  output logic             err_overflow,
  output logic             err_underflow
);

  logic tx_ovf, tx_udf, rx_ovf, rx_udf;
  logic err_overflow_q, err_underflow_q;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (put_req),
    .push_data_i (data_in),
    .pop_i       (acc_rd_req),
    .pop_data_o  (acc_rd_data),
    .pop_valid_o (acc_rd_valid),
    .empty_o     (to_acc_empty),
    .full_o      (to_acc_full),
    .ovf_o       (tx_ovf),
    .udf_o       (tx_udf)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (acc_wr_req),
    .push_data_i (acc_wr_data),
    .pop_i       (get_req),
    .pop_data_o  (data_out),
    .pop_valid_o (data_out_valid),
    .empty_o     (from_acc_empty),
    .full_o      (from_acc_full),
    .ovf_o       (rx_ovf),
    .udf_o       (rx_udf)
  );

  // Error flags latch on any FIFO's error pulse and clear only on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      err_overflow_q  <= err_overflow_q | tx_ovf | rx_ovf;
      err_underflow_q <= err_underflow_q | tx_udf | rx_udf;
    end
  end

  assign err_overflow  = err_overflow_q;
  assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_accel_fifo_port.sv
// Randomised + directed bench for accel_fifo_port against a queue-based model.
module tb_accel_fifo_port;

  localparam int W = 128;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         put_req = 1'b0, get_req = 1'b0, acc_rd_req = 1'b0, acc_wr_req = 1'b0;
  logic [W-1:0] data_in = '0, acc_wr_data = '0;
  logic [W-1:0] data_out, acc_rd_data;
  logic         data_out_valid, acc_rd_valid;
  logic         to_acc_empty, to_acc_full, from_acc_empty, from_acc_full;
  logic         err_overflow, err_underflow;

  accel_fifo_port #(.WIDTH(W), .DEPTH(D)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .put_req        (put_req),
    .data_in        (data_in),
    .get_req        (get_req),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .to_acc_empty   (to_acc_empty),
    .to_acc_full    (to_acc_full),
    .from_acc_empty (from_acc_empty),
    .from_acc_full  (from_acc_full),
    .acc_rd_req     (acc_rd_req),
    .acc_rd_data    (acc_rd_data),
    .acc_rd_valid   (acc_rd_valid),
    .acc_wr_req     (acc_wr_req),
    .acc_wr_data    (acc_wr_data),
    .err_overflow   (err_overflow),
    .err_underflow  (err_underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model
  logic [W-1:0] m_tx[$];
  logic [W-1:0] m_rx[$];
  logic [W-1:0] m_dout, m_ard;
  bit           m_dval, m_aval, m_ovf, m_udf;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_tx.delete();
    m_rx.delete();
    m_dout = '0; m_ard = '0;
    m_dval = 0; m_aval = 0; m_ovf = 0; m_udf = 0;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ":data_out"},       data_out,       m_dout);
    chk({ctx, ":data_out_valid"}, data_out_valid, W'(m_dval));
    chk({ctx, ":acc_rd_data"},    acc_rd_data,    m_ard);
    chk({ctx, ":acc_rd_valid"},   acc_rd_valid,   W'(m_aval));
    chk({ctx, ":to_acc_empty"},   to_acc_empty,   W'(m_tx.size() == 0));
    chk({ctx, ":to_acc_full"},    to_acc_full,    W'(m_tx.size() == D));
    chk({ctx, ":from_acc_empty"}, from_acc_empty, W'(m_rx.size() == 0));
    chk({ctx, ":from_acc_full"},  from_acc_full,  W'(m_rx.size() == D));
    chk({ctx, ":err_overflow"},   err_overflow,   W'(m_ovf));
    chk({ctx, ":err_underflow"},  err_underflow,  W'(m_udf));
  endtask

  // One clock: drive requests, advance the model, take the edge, check.
  task automatic cycle(input string ctx, input bit put, input logic [W-1:0] din,
                       input bit get, input bit ard, input bit awr,
                       input logic [W-1:0] awd);
    bit tx_full, tx_empty, rx_full, rx_empty;
    put_req = put; data_in = din; get_req = get;
    acc_rd_req = ard; acc_wr_req = awr; acc_wr_data = awd;
    tx_full  = (m_tx.size() == D);
    tx_empty = (m_tx.size() == 0);
    rx_full  = (m_rx.size() == D);
    rx_empty = (m_rx.size() == 0);
    m_dval = 0;
    m_aval = 0;
    if (ard) begin
      if (tx_empty) m_udf = 1;
      else begin m_ard = m_tx.pop_front(); m_aval = 1; end
    end
    if (get) begin
      if (rx_empty) m_udf = 1;
      else begin m_dout = m_rx.pop_front(); m_dval = 1; end
    end
    if (put) begin
      if (tx_full) m_ovf = 1;
      else m_tx.push_back(din);
    end
    if (awr) begin
      if (rx_full) m_ovf = 1;
      else m_rx.push_back(awd);
    end
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  task automatic idle(input string ctx);
    cycle(ctx, 0, '0, 0, 0, 0, '0);
  endtask

  task automatic do_reset();
    put_req = 0; get_req = 0; acc_rd_req = 0; acc_wr_req = 0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_all("reset");
  endtask

  function automatic logic [W-1:0] rnd_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    model_reset();
    do_reset();

    // fill TX to full
    for (int i = 1; i <= 8; i++) cycle("fill", 1, W'(i), 0, 0, 0, '0);
    chk("full_after_8", to_acc_full, 1);
    chk("not_empty_after_8", to_acc_empty, 0);

    // push while full, then drain in order
    cycle("ovf_push", 1, W'(9), 0, 0, 0, '0);
    chk("ovf_flag", err_overflow, 1);
    for (int i = 1; i <= 8; i++) begin
      cycle("drain", 0, '0, 0, 1, 0, '0);
      chk("drain_order", acc_rd_data, W'(i));
    end
    idle("drain_idle");
    cycle("drain_extra", 0, '0, 0, 1, 0, '0);

    // RX underflow
    do_reset();
    cycle("rx_udf", 0, '0, 1, 0, 0, '0);
    chk("rx_udf_flag", err_underflow, 1);
    chk("rx_udf_dout", data_out, '0);
    idle("rx_udf_idle");

    // simultaneous push/pop on RX with 3 stored words
    do_reset();
    cycle("rx_a", 0, '0, 0, 0, 1, W'('hA));
    cycle("rx_b", 0, '0, 0, 0, 1, W'('hB));
    cycle("rx_c", 0, '0, 0, 0, 1, W'('hC));
    cycle("rx_simul", 0, '0, 1, 0, 1, W'('hD));
    chk("rx_simul_data", data_out, W'('hA));
    chk("rx_simul_valid", data_out_valid, 1);
    for (int i = 0; i < 4; i++) cycle("rx_drain", 0, '0, 1, 0, 0, '0);
    chk("rx_drain_last", data_out, W'('hD));

    // pointer wrap: 20 push/pop pairs on both FIFOs
    do_reset();
    for (int i = 0; i < 3; i++) cycle("wrap_prime", 1, rnd_word(), 0, 0, 1, rnd_word());
    for (int i = 0; i < 20; i++) cycle("wrap", 1, rnd_word(), 1, 1, 1, rnd_word());
    for (int i = 0; i < 4; i++) cycle("wrap_drain", 0, '0, 1, 1, 0, '0);
    chk("wrap_no_ovf", err_overflow, 0);

    // async reset with TX holding 5 words
    do_reset();
    for (int i = 0; i < 5; i++) cycle("pre_async", 1, W'(i + 'h20), 0, 0, 0, '0);
    put_req = 0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_empty", to_acc_empty, 1);
    chk("async_full", to_acc_full, 0);
    model_reset();
    put_req = 1; data_in = W'('h55);
    @(posedge clk);
    #1;
    put_req = 0;
    reset_n = 1'b1;
    check_all("in_reset_ignored");
    cycle("post_async_pop", 0, '0, 0, 1, 0, '0);
    chk("post_async_udf", err_underflow, 1);

    // random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 200 == 199) do_reset();
      cycle("rand",
            $urandom_range(0, 99) < 55, rnd_word(),
            $urandom_range(0, 99) < 45,
            $urandom_range(0, 99) < 45,
            $urandom_range(0, 99) < 55, rnd_word());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
